// File: rtl/voice_alloc.sv
// Four-voice note allocator with age-based voice stealing.
// Each voice holds a note number, a velocity and a 2-bit age (0 = newest).
// Active voices always carry distinct ages 0..k-1; the oldest (age 3) is the
// steal victim when a new note arrives and every voice is busy.
module voice_alloc (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ce,
   input  logic       i_ev_valid,
   input  logic       i_ev_on,
   input  logic [6:0] i_ev_note,
   input  logic [6:0] i_ev_vel,
   input  logic       i_all_off,
   output logic [6:0] o_note_num_0,
   output logic [6:0] o_note_num_1,
   output logic [6:0] o_note_num_2,
   output logic [6:0] o_note_num_3,
   output logic [6:0] o_note_vel_0,
   output logic [6:0] o_note_vel_1,
   output logic [6:0] o_note_vel_2,
   output logic [6:0] o_note_vel_3,
   output logic [3:0] o_voice_active,
   output logic       o_steal
);

   // Registered voice state
   logic [6:0] r_num    [4];
   logic [6:0] r_vel    [4];
   logic [1:0] r_age    [4];
   logic [3:0] r_active;
   logic       r_steal;

   // Next-state values
   logic [6:0] w_num    [4];
   logic [6:0] w_vel    [4];
   logic [1:0] w_age    [4];
   logic [3:0] w_active;
   logic       w_steal;

   // Event decode and voice search results
   logic       w_note_on;
   logic       w_hit;
   logic [1:0] w_hit_idx;
   logic       w_has_free;
   logic [1:0] w_free_idx;
   logic [1:0] w_victim_idx;
   logic [1:0] w_tgt_idx;

   // A note-on with zero velocity is a note-off by MIDI convention.
   assign w_note_on = i_ev_on && (i_ev_vel != 7'd0);

   // Locate the matching active voice, the lowest free voice and the oldest voice
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
      w_hit        = 1'b0;
      w_hit_idx    = 2'd0;
      w_has_free   = 1'b0;
      w_free_idx   = 2'd0;
      w_victim_idx = 2'd0;
      // Scanning downward lets the lowest index win.
      for (int i = 3; i >= 0; i--) begin
         if (r_active[i] && (r_num[i] == i_ev_note)) begin
            w_hit     = 1'b1;
            w_hit_idx = 2'(i);
         end
         if (!r_active[i]) begin
            w_has_free = 1'b1;
            w_free_idx = 2'(i);
         end
         if (r_age[i] == 2'd3) begin
            w_victim_idx = 2'(i);
         end
      end
   end

   assign w_tgt_idx = w_has_free ? w_free_idx : w_victim_idx;

   // Compute the next voice state from the sampled event
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_num[i] = r_num[i];
         w_vel[i] = r_vel[i];
         w_age[i] = r_age[i];
      end
      w_active = r_active;
      w_steal  = 1'b0;

      if (i_ce) begin
         if (i_all_off) begin
            // Panic: silence everything but keep the note numbers; any event is dropped.
            for (int i = 0; i < 4; i++) begin
               w_vel[i] = 7'd0;
               w_age[i] = 2'd0;
            end
            w_active = 4'b0000;
         end else if (i_ev_valid) begin
            if (w_note_on) begin
               if (w_hit) begin
                  // Retrigger: only voices newer than the retriggered one age by one.
                  for (int i = 0; i < 4; i++) begin
                     if (r_active[i] && (r_age[i] < r_age[w_hit_idx])) begin
                        w_age[i] = r_age[i] + 2'd1;
                     end
                  end
                  w_vel[w_hit_idx] = i_ev_vel;
                  w_age[w_hit_idx] = 2'd0;
               end else begin
                  // New note: every sounding voice ages; the target is overwritten below.
                  for (int i = 0; i < 4; i++) begin
                     if (r_active[i]) begin
                        w_age[i] = r_age[i] + 2'd1;
                     end
                  end
                  w_num[w_tgt_idx]    = i_ev_note;
                  w_vel[w_tgt_idx]    = i_ev_vel;
                  w_age[w_tgt_idx]    = 2'd0;
                  w_active[w_tgt_idx] = 1'b1;
                  w_steal             = !w_has_free;
               end
            end else if (w_hit) begin
               // Note-off: voices older than the released one close the gap.
               for (int i = 0; i < 4; i++) begin
                  if (r_active[i] && (r_age[i] > r_age[w_hit_idx])) begin
                     w_age[i] = r_age[i] - 2'd1;
                  end
               end
               w_vel[w_hit_idx]    = 7'd0;
               w_age[w_hit_idx]    = 2'd0;
               w_active[w_hit_idx] = 1'b0;
            end
         end
      end
   end

   // Voice state register with synchronous reset
   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         for (int i = 0; i < 4; i++) begin
            r_num[i] <= 7'd0;
            r_vel[i] <= 7'd0;
            r_age[i] <= 2'd0;
         end
         r_active <= 4'b0000;
         r_steal  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_num[i] <= w_num[i];
            r_vel[i] <= w_vel[i];
            r_age[i] <= w_age[i];
         end
         r_active <= w_active;
         r_steal  <= w_steal;
      end
   end

   assign o_note_num_0   = r_num[0];
   assign o_note_num_1   = r_num[1];
   assign o_note_num_2   = r_num[2];
   assign o_note_num_3   = r_num[3];
   assign o_note_vel_0   = r_vel[0];
   assign o_note_vel_1   = r_vel[1];
   assign o_note_vel_2   = r_vel[2];
   assign o_note_vel_3   = r_vel[3];
   assign o_voice_active = r_active;
   assign o_steal        = r_steal;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed self-checking bench for voice_alloc with hand-computed expectations.
module tb_voice_alloc;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ce = 1'b1;
   logic       ev_valid = 1'b0;
   logic       ev_on = 1'b0;
   logic [6:0] ev_note = 7'd0;
   logic [6:0] ev_vel = 7'd0;
   logic       all_off = 1'b0;
   logic [6:0] num0, num1, num2, num3;
   logic [6:0] vel0, vel1, vel2, vel3;
   logic [3:0] active;
   logic       steal;

   int n_checks = 0;
   int n_pass   = 0;

   voice_alloc dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_ce           (ce),
      .i_ev_valid     (ev_valid),
      .i_ev_on        (ev_on),
      .i_ev_note      (ev_note),
      .i_ev_vel       (ev_vel),
      .i_all_off      (all_off),
      .o_note_num_0   (num0),
      .o_note_num_1   (num1),
      .o_note_num_2   (num2),
      .o_note_num_3   (num3),
      .o_note_vel_0   (vel0),
      .o_note_vel_1   (vel1),
      .o_note_vel_2   (vel2),
      .o_note_vel_3   (vel3),
      .o_voice_active (active),
      .o_steal        (steal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Apply one cycle of inputs, let the edge take them, then park strobes idle.
   task automatic step(input logic c, input logic r, input logic v, input logic on,
                       input logic [6:0] n, input logic [6:0] vl, input logic ao);
      ce = c; rst = r; ev_valid = v; ev_on = on; ev_note = n; ev_vel = vl; all_off = ao;
      @(posedge clk);
      #1;
      ce = 1'b1; rst = 1'b0; ev_valid = 1'b0; all_off = 1'b0;
   endtask

   task automatic note_on(input logic [6:0] n, input logic [6:0] vl);
      step(1'b1, 1'b0, 1'b1, 1'b1, n, vl, 1'b0);
   endtask

   task automatic note_off(input logic [6:0] n);
      step(1'b1, 1'b0, 1'b1, 1'b0, n, 7'd0, 1'b0);
   endtask

   // Reset with a competing note-on that must be discarded.
   task automatic do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1, 7'd10, 7'd20, 1'b0);
   endtask

   initial begin
      // Reset overrides a simultaneous event
      do_reset();
      check("rst_num", {num3, num2, num1, num0}, 32'd0);
      check("rst_vel", {vel3, vel2, vel1, vel0}, 32'd0);
      check("rst_active", active, 4'b0000);
      check("rst_steal", steal, 1'b0);

      // Single note-on lands on voice 0 after one edge
      note_on(7'd60, 7'd100);
      check("first_num0", num0, 7'd60);
      check("first_vel0", vel0, 7'd100);
      check("first_active", active, 4'b0001);
      check("first_steal", steal, 1'b0);

      // Fill all four voices, then steal the oldest (voice 0)
      do_reset();
      note_on(7'd60, 7'd90);
      note_on(7'd64, 7'd90);
      note_on(7'd67, 7'd90);
      note_on(7'd72, 7'd90);
      check("full_active", active, 4'b1111);
      check("full_steal", steal, 1'b0);
      note_on(7'd76, 7'd80);
      check("steal_num0", num0, 7'd76);
      check("steal_vel0", vel0, 7'd80);
      check("steal_pulse", steal, 1'b1);
      check("steal_active", active, 4'b1111);
      // Next oldest is now voice 1; CE=0 on the following cycle keeps STEAL low
      step(1'b0, 1'b0, 1'b1, 1'b1, 7'd77, 7'd10, 1'b0);
      check("ce0_steal", steal, 1'b0);
      check("ce0_num1", num1, 7'd64);
      note_on(7'd77, 7'd10);
      check("steal2_num1", num1, 7'd77);
      check("steal2_pulse", steal, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
      check("steal_one_cycle", steal, 1'b0);

      // Retrigger moves voice 0 to newest, so voice 1 becomes the victim
      do_reset();
      note_on(7'd60, 7'd90);
      note_on(7'd64, 7'd90);
      note_on(7'd67, 7'd90);
      note_on(7'd72, 7'd90);
      note_on(7'd60, 7'd50);
      check("retrig_vel0", vel0, 7'd50);
      check("retrig_steal", steal, 1'b0);
      check("retrig_nums", {num3, num2, num1, num0}, {4'd0, 7'd72, 7'd67, 7'd64, 7'd60});
      note_on(7'd76, 7'd70);
      check("retrig_steal_num1", num1, 7'd76);
      check("retrig_steal_vel1", vel1, 7'd70);
      check("retrig_keep_vel0", vel0, 7'd50);
      check("retrig_steal_pulse", steal, 1'b1);

      // Note-off ages close the gap so the correct voice is stolen later
      do_reset();
      note_on(7'd60, 7'd90);
      note_on(7'd64, 7'd90);
      note_on(7'd67, 7'd90);
      note_off(7'd64);
      check("gap_active", active, 4'b0101);
      note_on(7'd72, 7'd90);
      note_on(7'd74, 7'd90);
      check("gap_num1", num1, 7'd72);
      check("gap_num3", num3, 7'd74);
      note_on(7'd80, 7'd90);
      check("gap_steal_num0", num0, 7'd80);
      check("gap_steal_nums", {num3, num2, num1}, {7'd74, 7'd67, 7'd72});

      // Note-off frees voice 0 for reuse; unmatched note-off changes nothing
      do_reset();
      note_on(7'd60, 7'd90);
      note_on(7'd64, 7'd90);
      note_off(7'd60);
      check("off_vel0", vel0, 7'd0);
      check("off_num0_kept", num0, 7'd60);
      check("off_active", active, 4'b0010);
      note_on(7'd62, 7'd40);
      check("reuse_num0", num0, 7'd62);
      check("reuse_active", active, 4'b0011);
      note_off(7'd99);
      check("nomatch_active", active, 4'b0011);
      check("nomatch_vel", {vel3, vel2, vel1, vel0}, {4'd0, 7'd0, 7'd0, 7'd90, 7'd40});

      // Velocity-0 note-on acts as note-off
      note_on(7'd62, 7'd0);
      check("vel0_off_active", active, 4'b0010);
      check("vel0_off_vel0", vel0, 7'd0);
      // CE=0 ignores a note-on
      step(1'b0, 1'b0, 1'b1, 1'b1, 7'd65, 7'd30, 1'b0);
      check("ce0_active", active, 4'b0010);
      check("ce0_nums", {num3, num2, num1, num0}, {4'd0, 7'd0, 7'd0, 7'd64, 7'd62});
      // CE=0 also ignores ALL_OFF
      step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1);
      check("ce0_alloff_active", active, 4'b0010);
      // ALL_OFF drops a simultaneous note-on
      step(1'b1, 1'b0, 1'b1, 1'b1, 7'd70, 7'd55, 1'b1);
      check("alloff_vel", {vel3, vel2, vel1, vel0}, 32'd0);
      check("alloff_active", active, 4'b0000);
      check("alloff_nums", {num3, num2, num1, num0}, {4'd0, 7'd0, 7'd0, 7'd64, 7'd62});
      note_on(7'd70, 7'd5);
      check("after_alloff_num0", num0, 7'd70);
      check("after_alloff_active", active, 4'b0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 The block SHALL have no parameters; the voice count is fixed at 4 and note/velocity widths are fixed at 7 bits.
REQ-002 CLK  in  1  system clock; one clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 CE  in  1  clock enable; events are sampled only on edges where CE=1.
REQ-005 EV_VALID  in  1  one-cycle note event strobe.
REQ-006 EV_ON  in  1  event type: 1=note-on, 0=note-off.
REQ-007 EV_NOTE  in  7  MIDI note number of the event.
REQ-008 EV_VEL  in  7  MIDI velocity of the event; ignored for note-off.
REQ-009 ALL_OFF  in  1  panic strobe that silences all voices.
REQ-010 NOTE_NUM_0..NOTE_NUM_3  out  7 each  per-voice note number feeding the oscillator bank.
REQ-011 NOTE_VEL_0..NOTE_VEL_3  out  7 each  per-voice velocity; 0 means silent.
REQ-012 VOICE_ACTIVE  out  4  bit i=1 when voice i holds a sounding note.
REQ-013 STEAL  out  1  one-cycle pulse when a note-on evicted a sounding voice.

Function
REQ-014 All outputs SHALL be registered; an event sampled at edge N SHALL be visible on the outputs after edge N, i.e. with 1-cycle latency.
REQ-015 The block SHALL keep a 2-bit age per voice; active voices always hold distinct ages 0..k-1 (k = active count), 0 = newest.
REQ-016 A note-on with EV_VEL=0 SHALL be treated as a note-off (MIDI convention).
REQ-017 Note-on matching an active voice's NOTE_NUM (retrigger) SHALL write EV_VEL to that voice, set its age to 0, and increment ages of active voices younger than its previous age.
REQ-018 Note-on with no match and a free voice SHALL take the lowest-index free voice, write num/vel, set active, age 0, and increment all other active ages.
REQ-019 Note-on with no match and all 4 voices active SHALL steal the voice with age 3, write num/vel, set its age to 0, increment the other three ages, and pulse STEAL for exactly one cycle.
REQ-020 Note-off matching an active voice SHALL set its NOTE_VEL to 0, clear VOICE_ACTIVE, and decrement ages of active voices older than it; NOTE_NUM SHALL be retained.
REQ-021 Note-off with no matching active voice SHALL change no state.
REQ-022 Match comparisons SHALL consider only voices with VOICE_ACTIVE=1; inactive voices with stale NOTE_NUM never match.
REQ-023 ALL_OFF with CE=1 SHALL zero all NOTE_VEL, clear VOICE_ACTIVE and ages, and retain NOTE_NUM; any EV_VALID in the same cycle is dropped.
REQ-024 With CE=0, EV_VALID and ALL_OFF SHALL be ignored, all state SHALL hold, and STEAL SHALL be 0.
REQ-025 At most one event SHALL be processed per cycle; back-to-back events on consecutive CE cycles SHALL each be fully applied.
REQ-026 STEAL SHALL be 0 in every cycle not covered by REQ-019.

Reset
REQ-027 RST=1 at a clock edge SHALL force all NOTE_NUM, NOTE_VEL, ages, VOICE_ACTIVE and STEAL to 0, overriding CE and any event.
REQ-028 RST asserted mid-operation SHALL discard the event in that cycle; the first post-reset note-on SHALL land on voice 0.

Verification
REQ-029 Reset, then note-on 60/100 -> next cycle NOTE_NUM_0=60, NOTE_VEL_0=100, VOICE_ACTIVE=0001, STEAL=0.
REQ-030 Note-ons 60, 64, 67, 72 (vel 90), then note-on 76/80 -> voice 0 stolen: NOTE_NUM_0=76, NOTE_VEL_0=80, STEAL pulses 1 cycle, VOICE_ACTIVE=1111.
REQ-031 Four voices 60/64/67/72, retrigger 60 with vel 50, then note-on 76 -> voice 1 (64) stolen, NOTE_VEL_0=50 unchanged.
REQ-032 Voices 60/64 active, note-off 60, then note-on 62 -> voice 0 reused: NOTE_NUM_0=62, VOICE_ACTIVE=0011; note-off 99 -> no change.
REQ-033 Note-on 60/0 -> treated as note-off; note-on 65 with CE=0 -> ignored; ALL_OFF with simultaneous note-on 70 -> all NOTE_VEL=0, VOICE_ACTIVE=0000, NOTE_NUM unchanged.
